full_adder_32bit: RTL and testbench
===================================

Name: full_adder_32bit

Overview:
- Registered two's-complement adder/subtractor for the datapath ALU.
- Computes a+b or a−b (a + ~b + 1) and reports sum, unsigned carry-out and signed overflow.
- Operands are sampled on a rising clock edge; results are registered with fixed 1-cycle latency.
- Ripple-carry structure built from 1-bit full-adder cells.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be ≥2; all tests use 32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- subtract  input  1  0 = a+b, 1 = a−b; also acts as carry-in to bit 0
- out_valid  output  1  registered; result valid
- sum  output  WIDTH  registered result
- carryout  output  1  registered carry out of the MSB cell
- overflow  output  1  registered signed overflow

Behaviour:
- Reset is synchronous, active-high: on a clk edge with reset=1, sum=0, carryout=0, overflow=0, out_valid=0. Reset overrides in_valid. Reset mid-stream discards the in-flight result.
- Effective B: bi = b XOR {WIDTH{subtract}}. Carry-in to bit 0 = subtract.
- Cell i computes:
  - s[i] = a[i]^bi[i]^c[i]
  - c[i+1] = a[i]&bi[i] | c[i]&(a[i]^bi[i])
- carryout = c[WIDTH], the raw carry. For subtraction, 1 means no borrow (a ≥ b unsigned).
- overflow = c[WIDTH] XOR c[WIDTH−1], equivalent to operands of equal effective sign producing a result of the opposite sign.
- Sum wraps modulo 2^WIDTH.
- Latency: when in_valid=1 at edge N, sum/carryout/overflow and out_valid=1 are available after edge N.
- When in_valid=0: out_valid=0 on the next edge and the data outputs hold their previous values.
- Throughput: one operation per cycle; no backpressure.
- Combinational path from a/b/subtract to the registers only; no combinational input→output paths.

Optional Feature:
- Macro: FULL_ADDER_32BIT_FLAGS_EN.
- Defined: adds two ports, registered and updated under the same valid/reset rules as sum, both reset to 0:
  - zero (output, 1): 1 when the next sum is all-zeros.
  - negative (output, 1): the MSB of the next sum.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg: localparam ADDER_WIDTH=32; op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, full_adder_1bit (a, b, cin → sum, cout), instantiated WIDTH times via a generate loop.
- Top level holds the B-inversion, overflow logic, flag logic and output registers.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 → sum=0, carryout=0, overflow=0, out_valid=0. Release reset → first result appears 1 cycle later.
- Sub a=FFFFFFFF, b=FFFFFFFF → sum=00000000, carryout=1, overflow=0 (zero=1 with FLAGS_EN).
- Add a=AAAAAAAA, b=AAAAAAAA → sum=55555554, carryout=1, overflow=1. Add a=55555555, b=55555555 → sum=AAAAAAAA, carryout=0, overflow=1.
- Add a=22222222, b=AAAAAAAA → sum=CCCCCCCC, carryout=0, overflow=0.
- Sub a=00000028, b=00000004 → sum=00000024, carryout=1, overflow=0. Sub a=4, b=0x28 → sum=FFFFFFDC, carryout=0, overflow=0 (negative=1 with FLAGS_EN).
- Back-to-back: four valid ops on consecutive cycles, then in_valid=0 → each result lands exactly 1 cycle after its inputs; out_valid drops after the last result and the outputs hold. Sub a=80000000, b=1 → sum=7FFFFFFF, overflow=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared datapath ALU definitions: default adder width and add/sub op encoding.
package alu_pkg;

    localparam int unsigned ADDER_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1bit.sv
// Single full-adder cell used as the ripple-carry building block.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder_32bit.sv
// Registered ripple-carry adder/subtractor with carry-out and signed overflow.
// Define FULL_ADDER_32BIT_FLAGS_EN to add registered zero/negative result flags.
module full_adder_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
`ifdef FULL_ADDER_32BIT_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative
`endif
);

    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carryout_q;
    logic             overflow_q;

    // Subtraction is a + ~b + 1: the op bit doubles as the carry-in.
    always_comb begin
        bi   = b;
        c[0] = 1'b0;
        unique case (subtract)
            OP_ADD: begin
                bi   = b;
                c[0] = 1'b0;
            end
            OP_SUB: begin
                bi   = ~b;
                c[0] = 1'b1;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_1bit u_cell (
            .a    (a[i]),
            .b    (bi[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q      <= s;
                carryout_q <= c[WIDTH];
                overflow_q <= c[WIDTH] ^ c[WIDTH-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;

`ifdef FULL_ADDER_32BIT_FLAGS_EN
    logic zero_q;
    logic negative_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else if (in_valid) begin
            zero_q     <= (s == '0);
            negative_q <= s[WIDTH-1];
        end
    end

    assign zero     = zero_q;
    assign negative = negative_q;
`endif

endmodule

// File: tb/tb_full_adder_32bit.sv
// Randomized and directed self-checking bench for full_adder_32bit.
module tb_full_adder_32bit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         subtract;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;
`ifdef FULL_ADDER_32BIT_FLAGS_EN
    logic         zero;
    logic         negative;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the outputs should show after the next edge.
    logic         m_valid;
    logic [W-1:0] m_sum;
    logic         m_carry;
    logic         m_ovf;

    full_adder_32bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .subtract  (subtract),
        .out_valid (out_valid),
        .sum       (sum),
        .carryout  (carryout),
        .overflow  (overflow)
`ifdef FULL_ADDER_32BIT_FLAGS_EN
        ,
        .zero      (zero),
        .negative  (negative)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic model of the registered result.
    task automatic model(input logic r, input logic v, input logic s,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] be;
        logic [W:0]   full;
        if (r) begin
            m_valid = 1'b0;
            m_sum   = '0;
            m_carry = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_valid = v;
            if (v) begin
                be      = s ? ~y : y;
                full    = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, s};
                m_sum   = full[W-1:0];
                m_carry = full[W];
                m_ovf   = (x[W-1] == be[W-1]) && (m_sum[W-1] != x[W-1]);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s,
                        input logic [W-1:0] x, input logic [W-1:0] y);
        reset    = r;
        in_valid = v;
        subtract = s;
        a        = x;
        b        = y;
        model(r, v, s, x, y);
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("sum",       64'(sum),       64'(m_sum));
        check("carryout",  64'(carryout),  64'(m_carry));
        check("overflow",  64'(overflow),  64'(m_ovf));
`ifdef FULL_ADDER_32BIT_FLAGS_EN
        check("zero",      64'(zero),      64'(r ? 1'b0 : (m_sum == '0)));
        check("negative",  64'(negative),  64'(r ? 1'b0 : m_sum[W-1]));
`endif
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] es,
                                 input logic ec, input logic eo);
        check({tag, ".sum"}, 64'(sum),      64'(es));
        check({tag, ".c"},   64'(carryout), 64'(ec));
        check({tag, ".v"},   64'(overflow), 64'(eo));
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        subtract = 1'b0;
        a        = 32'h1234_5678;
        b        = 32'h1111_1111;

        // Reset held with in_valid=1 must keep everything cleared.
        step(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.sum",   64'(sum),       64'd0);

        // Directed cases; first result arrives one edge after release.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_result("subff", 32'h0000_0000, 1'b1, 1'b0);
        check("subff.valid", 64'(out_valid), 64'd1);
        step(1'b0, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        expect_result("addaa", 32'h5555_5554, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h5555_5555, 32'h5555_5555);
        expect_result("add55", 32'hAAAA_AAAA, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h2222_2222, 32'hAAAA_AAAA);
        expect_result("add2a", 32'hCCCC_CCCC, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0028, 32'h0000_0004);
        expect_result("sub28", 32'h0000_0024, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0028);
        expect_result("sub04", 32'hFFFF_FFDC, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001);
        expect_result("submin", 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Idle cycles: valid drops, data holds the last result.
        step(1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        expect_result("hold1", 32'h7FFF_FFFF, 1'b1, 1'b1);
        check("hold1.valid", 64'(out_valid), 64'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        expect_result("hold2", 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Reset mid-stream discards the in-flight op.
        step(1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002);
        step(1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004);
        check("midrst.sum", 64'(sum), 64'd0);

        // Random traffic with back-to-back bursts and idle gaps.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic         v;
            logic         s;
            logic         r;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = x;
                1: x = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                default: ;
            endcase
            v = ($urandom_range(0, 3) != 0);
            s = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 49) == 0);
            step(r, v, s, x, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
